seq_detect_param_jdl25175: RTL

//  Parametrised Moore sequence-detector FSM, next generation of the HW5 dense-state machines.
//  - Recognises a run-time loadable pattern of DEPTH symbols, each IN_WIDTH bits wide.
//  - Raises a Moore match output and keeps a saturating match count.
//  - Adds enable, overlap mode and a count clear.
//  - Sits after an input synchroniser; feeds status LEDs/counters in the HW lab top level.

---
 rtl/seq_detect_param_jdl25175.sv | 93 +++++++++
 1 files changed

// File: rtl/seq_detect_param_jdl25175.sv
// Moore sequence detector for a run-time loadable pattern of DEPTH symbols,
// with enable, overlap mode, and a saturating, clearable match counter.
module seq_detect_param_jdl25175 #(
    parameter int unsigned IN_WIDTH    = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STATE_WIDTH = 3,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter bit          OVERLAP     = 1'b1,
    parameter logic [DEPTH*IN_WIDTH-1:0] RESET_PATTERN = 8'h12
) (
    input  logic                      clock,
    input  logic                      init,
    input  logic [IN_WIDTH-1:0]       in,
    input  logic                      enable,
    input  logic                      load,
    input  logic [DEPTH*IN_WIDTH-1:0] pattern,
    input  logic                      clear,
    output logic                      out,
    output logic [STATE_WIDTH-1:0]    state,
    output logic [COUNT_WIDTH-1:0]    count
);

    localparam int unsigned PAT_WIDTH = DEPTH * IN_WIDTH;
    localparam logic [STATE_WIDTH-1:0] FULL = STATE_WIDTH'(DEPTH);
    localparam logic [STATE_WIDTH-1:0] ONE  = STATE_WIDTH'(1);

    logic [PAT_WIDTH-1:0]   pat_q;
    logic [STATE_WIDTH-1:0] state_d;
    logic                   out_d;
    logic [COUNT_WIDTH-1:0] count_d;
    logic [IN_WIDTH-1:0]    cur_sym;
    logic [IN_WIDTH-1:0]    sym0;
    logic                   hit;

    // State register; the match flag is registered alongside it so it
    // always equals (state == DEPTH) without any in->out path.
    always_ff @(posedge clock or negedge init) begin
        if (!init) begin
            state <= '0;
            out   <= 1'b0;
            count <= '0;
            pat_q <= RESET_PATTERN;
        end else begin
            state <= state_d;
            out   <= out_d;
            count <= count_d;
            if (load) begin
                pat_q <= pattern;
            end
        end
    end

    // Next-state logic: single-symbol restart on mismatch, no prefix fallback.
    always_comb begin
        sym0    = pat_q[IN_WIDTH-1:0];
        cur_sym = pat_q[IN_WIDTH-1:0];
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (state == STATE_WIDTH'(k)) begin
                cur_sym = pat_q[k*IN_WIDTH +: IN_WIDTH];
            end
        end

        state_d = state;
        if (load) begin
            state_d = '0;
        end else if (state > FULL) begin
            state_d = '0;
        end else if (enable) begin
            if (state == FULL) begin
                state_d = (OVERLAP && (in == sym0)) ? ONE : '0;
            end else if (in == cur_sym) begin
                state_d = state + ONE;
            end else if (in == sym0) begin
                state_d = ONE;
            end else begin
                state_d = '0;
            end
        end
    end

    // Output/counter logic: count on entry into DEPTH; clear wins over increment.
    always_comb begin
        out_d   = (state_d == FULL);
        hit     = enable && !load && (state != FULL) && (state_d == FULL);
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (hit && (count != {COUNT_WIDTH{1'b1}})) begin
            count_d = count + COUNT_WIDTH'(1);
        end
    end

endmodule
